shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_pkg.sv | 21 ++
 rtl/shift_add_ctrl.sv | 82 ++++++++
 rtl/shift_add_multiplier.sv | 111 +++++++++++
 tb/tb_shift_add_multiplier.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// ============================================================================
// Module      : shift_add_pkg
// Description : Shared FSM state encoding and default operand width for the
//               shift-add multiplier. Optional feature macro: SHIFT_ADD_SIGNED_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

package shift_add_pkg;

   localparam int unsigned L_WORD_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : shift_add_pkg

`default_nettype wire

// File: rtl/shift_add_ctrl.sv
// ============================================================================
// Module      : shift_add_ctrl
// Description : Sequencer for the shift-add multiplier: FSM, iteration counter,
//               ready and done pulse. Optional feature macro: SHIFT_ADD_SIGNED_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_add_ctrl
   import shift_add_pkg::*;
#(
   parameter int L_WORD = L_WORD_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic zero_op,
   input  logic mplier_last,
   output logic ready,
   output logic done,
   output logic accept,
   output logic run,
   output logic finish
);

   localparam int CNT_W = (L_WORD > 1) ? $clog2(L_WORD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L_WORD - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      finish  = 1'b0;
      // ready is forced low by an asserted reset even before the edge acts
      ready   = reset && (state_q != RUN);
      accept  = start && ready;
      run     = (state_q == RUN);
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               cnt_d = '0;
               if (zero_op) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mplier_last || (cnt_q == CNT_LAST)) begin
               finish  = 1'b1;
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

endmodule : shift_add_ctrl

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module      : shift_add_multiplier
// Description : Iterative shift-add multiplier with early termination; signed
//               operands supported when SHIFT_ADD_SIGNED_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_add_multiplier
   import shift_add_pkg::*;
#(
   parameter int L_WORD = L_WORD_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [L_WORD-1:0]     word1,
   input  logic [L_WORD-1:0]     word2,
   output logic [2*L_WORD-1:0]   product,
   output logic                  ready,
   output logic                  done
);

   logic [2*L_WORD-1:0] product_q, product_d;
   logic [2*L_WORD-1:0] mcand_q, mcand_d;
   logic [L_WORD-1:0]   mplier_q, mplier_d;
   logic [L_WORD-1:0]   mag1, mag2;
   logic [2*L_WORD-1:0] sum;
   logic                accept, run, finish, zero_op, mplier_last;

   assign zero_op     = (word1 == '0) || (word2 == '0);
   assign mplier_last = (mplier_q[L_WORD-1:1] == '0);
   assign sum         = product_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SHIFT_ADD_SIGNED_EN
   logic neg1, neg2, sign_q, sign_d;

   // -2^(L_WORD-1) negates to itself, which reads correctly as unsigned
   assign neg1 = signed_mode & word1[L_WORD-1];
   assign neg2 = signed_mode & word2[L_WORD-1];
   assign mag1 = neg1 ? -word1 : word1;
   assign mag2 = neg2 ? -word2 : word2;

   always_comb begin
      sign_d = sign_q;
      if (accept) sign_d = neg1 ^ neg2;
   end

   always_ff @(posedge clock) begin
      if (!reset) sign_q <= 1'b0;
      else        sign_q <= sign_d;
   end
`else
   logic unused_signed_mode;

   assign unused_signed_mode = signed_mode;
   assign mag1 = word1;
   assign mag2 = word2;
`endif

   always_comb begin
      product_d = product_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      if (accept) begin
         product_d = '0;
         mcand_d   = {{L_WORD{1'b0}}, mag1};
         mplier_d  = mag2;
      end else if (run) begin
         product_d = sum;
         mcand_d   = mcand_q << 1;
         mplier_d  = mplier_q >> 1;
`ifdef SHIFT_ADD_SIGNED_EN
         if (finish && sign_q) product_d = -sum;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         product_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
      end else begin
         product_q <= product_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
      end
   end

   shift_add_ctrl #(
      .L_WORD (L_WORD)
   ) u_ctrl (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .zero_op     (zero_op),
      .mplier_last (mplier_last),
      .ready       (ready),
      .done        (done),
      .accept      (accept),
      .run         (run),
      .finish      (finish)
   );

   assign product = product_q;

endmodule : shift_add_multiplier

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Directed self-checking bench for shift_add_multiplier (L_WORD=4);
//               signed expectations follow SHIFT_ADD_SIGNED_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

   logic       clock;
   logic       reset;
   logic       start;
   logic       signed_mode;
   logic [3:0] word1;
   logic [3:0] word2;
   logic [7:0] product;
   logic       ready;
   logic       done;

   int errors = 0;
   int checks = 0;

   shift_add_multiplier #(
      .L_WORD (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .signed_mode (signed_mode),
      .word1       (word1),
      .word2       (word2),
      .product     (product),
      .ready       (ready),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives a request at the current falling edge; accepted at the next rising edge.
   task automatic launch(input logic [3:0] w1, input logic [3:0] w2, input logic sm);
      word1       = w1;
      word2       = w2;
      signed_mode = sm;
      start       = 1'b1;
   endtask

   // Counts cycles from acceptance to done; leaves the bench at the done-cycle falling edge.
   task automatic wait_done(input string tag, input logic [7:0] exp_p, input int exp_lat, input bit hold);
      int lat;
      @(posedge clock);
      @(negedge clock);
      if (hold) begin
         word1 = 4'd1;
         word2 = 4'd1;
      end else begin
         start = 1'b0;
      end
      lat = 1;
      if (exp_lat > 1) check({tag, "_ready_run"}, {31'd0, ready}, 32'd0);
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      if (hold) start = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_product"}, {24'd0, product}, {24'd0, exp_p});
      check({tag, "_ready_done"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic check_hold(input string tag, input logic [7:0] exp_p);
      start = 1'b0;
      @(negedge clock);
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
      check({tag, "_hold"}, {24'd0, product}, {24'd0, exp_p});
   endtask

   initial begin
      int pulses;
      reset       = 1'b0;
      start       = 1'b0;
      signed_mode = 1'b0;
      word1       = 4'd0;
      word2       = 4'd0;
      @(negedge clock);
      @(negedge clock);
      check("rst_product", {24'd0, product}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready_low", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      #1;
      check("idle_ready", {31'd0, ready}, 32'd1);

      launch(4'd13, 4'd11, 1'b0);
      wait_done("u13x11", 8'd143, 5, 1'b0);
      check_hold("u13x11", 8'd143);

      launch(4'd0, 4'd9, 1'b0);
      wait_done("zero", 8'd0, 1, 1'b0);
      check_hold("zero", 8'd0);

      launch(4'd15, 4'd1, 1'b0);
      wait_done("early", 8'd15, 2, 1'b0);
      check_hold("early", 8'd15);

      launch(4'b1000, 4'b1000, 1'b1);
      wait_done("s8x8", 8'd64, 5, 1'b0);
      check_hold("s8x8", 8'd64);

`ifdef SHIFT_ADD_SIGNED_EN
      launch(4'b1101, 4'd5, 1'b1);
      wait_done("sm3x5", 8'hF1, 4, 1'b0);
      launch(4'd7, 4'b1111, 1'b1);
      wait_done("s7xm1", 8'hF9, 2, 1'b0);
      check_hold("s7xm1", 8'hF9);
`else
      launch(4'b1101, 4'd5, 1'b1);
      wait_done("sm3x5", 8'h41, 4, 1'b0);
      launch(4'd7, 4'b1111, 1'b1);
      wait_done("s7xm1", 8'd105, 5, 1'b0);
      check_hold("s7xm1", 8'd105);
`endif

      launch(4'b1101, 4'd13, 1'b0);
      wait_done("u13x13", 8'd169, 5, 1'b0);
      check_hold("u13x13", 8'd169);

      // Abort: reset low during the second RUN cycle
      launch(4'd13, 4'd11, 1'b0);
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_ready_rst", {31'd0, ready}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      check("abort_product", {24'd0, product}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      #1;
      check("abort_idle_ready", {31'd0, ready}, 32'd1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);
      launch(4'd2, 4'd3, 1'b0);
      wait_done("after_abort", 8'd6, 3, 1'b0);
      check_hold("after_abort", 8'd6);

      launch(4'd13, 4'd11, 1'b0);
      wait_done("held_start", 8'd143, 5, 1'b1);
      check_hold("held_start", 8'd143);

      launch(4'd5, 4'd3, 1'b0);
      wait_done("b2b_first", 8'd15, 3, 1'b0);
      launch(4'd7, 4'd7, 1'b0);
      wait_done("b2b_second", 8'd49, 4, 1'b0);
      check_hold("b2b_second", 8'd49);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_shift_add_multiplier

`default_nettype wire
